change_dispenser: RTL

//   Downstream of the vending control FSM. On end_trans, computes change (sum_money - price
//   on purchase, full sum_money on cancel) and pays it out one coin at a time in
//   20/10/5 denominations through a valid/ack handshake to the coin hopper. Tracks per-

---
 rtl/change_dispenser.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: computes change at the end of a transaction and pays it out greedily
// in 20/10/5 coins over a valid/ack handshake. Optional refill port enabled by COIN_REFILL_EN.
module change_dispenser #(
    parameter int W           = 8,
    parameter int CNT_W       = 6,
    parameter int INIT_CNT_5  = 10,
    parameter int INIT_CNT_10 = 10,
    parameter int INIT_CNT_20 = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             end_trans,
    input  logic             done,
    input  logic [W-1:0]     sum_money,
    input  logic [W-1:0]     price,
    input  logic             coin_ack,
`ifdef COIN_REFILL_EN
    input  logic             refill_valid,
    input  logic [2:0]       refill_coin,
`endif
    output logic [2:0]       coin,
    output logic             coin_valid,
    output logic             busy,
    output logic             change_done,
    output logic             short,
    output logic [W-1:0]     owed,
    output logic [CNT_W-1:0] cnt_5,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_20
);
    typedef enum logic [1:0] {IDLE, CALC, WAIT_ACK, FINISH} state_t;

    localparam logic [W-1:0]     D5      = W'(5);
    localparam logic [W-1:0]     D10     = W'(10);
    localparam logic [W-1:0]     D20     = W'(20);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                      state_q, state_d;
    logic [W-1:0]                rem_q, rem_d;
    logic [2:0]                  coin_q, coin_d;
    logic                        coin_valid_q, coin_valid_d;
    logic                        busy_q, busy_d;
    logic                        change_done_q, change_done_d;
    logic                        short_q, short_d;
    logic [W-1:0]                owed_q, owed_d;
    // index 0 = 5, 1 = 10, 2 = 20 (same bit order as the one-hot coin code)
    logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;

    logic [W-1:0] coin_val;
    logic         ack_take;
    logic [2:0]   inc, dec;

    always_comb begin
        case (coin_q)
            3'b001:  coin_val = D5;
            3'b010:  coin_val = D10;
            3'b100:  coin_val = D20;
            default: coin_val = '0;
        endcase
    end

    assign ack_take = (state_q == WAIT_ACK) && coin_valid_q && coin_ack;
    assign dec      = ack_take ? coin_q : 3'b000;

`ifdef COIN_REFILL_EN
    always_comb begin
        inc = 3'b000;
        if (refill_valid && (refill_coin == 3'b001 || refill_coin == 3'b010 ||
                             refill_coin == 3'b100))
            inc = refill_coin;
    end
`else
    assign inc = 3'b000;
`endif

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        coin_d       = coin_q;
        coin_valid_d = coin_valid_q;
        short_d      = short_q;
        owed_d       = owed_q;
        case (state_q)
            IDLE: begin
                if (end_trans) begin
                    if (done)
                        rem_d = (price > sum_money) ? '0 : sum_money - price;
                    else
                        rem_d = sum_money;
                    short_d = 1'b0;
                    owed_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (rem_q == '0) begin
                    short_d = 1'b0;
                    owed_d  = '0;
                    state_d = FINISH;
                end else if (rem_q >= D20 && cnt_q[2] != '0) begin
                    coin_d = 3'b100; coin_valid_d = 1'b1; state_d = WAIT_ACK;
                end else if (rem_q >= D10 && cnt_q[1] != '0) begin
                    coin_d = 3'b010; coin_valid_d = 1'b1; state_d = WAIT_ACK;
                end else if (rem_q >= D5 && cnt_q[0] != '0) begin
                    coin_d = 3'b001; coin_valid_d = 1'b1; state_d = WAIT_ACK;
                end else begin
                    short_d = 1'b1;
                    owed_d  = rem_q;
                    state_d = FINISH;
                end
            end
            WAIT_ACK: begin
                if (ack_take) begin
                    rem_d        = rem_q - coin_val;
                    coin_d       = 3'b000;
                    coin_valid_d = 1'b0;
                    state_d      = CALC;
                end
            end
            default: state_d = IDLE;
        endcase
        change_done_d = (state_d == FINISH);
        busy_d        = (state_d != IDLE);
    end

    // A simultaneous refill and payout of the same denomination cancel out.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (dec[i] && !inc[i])
                cnt_d[i] = cnt_q[i] - 1'b1;
            else if (inc[i] && !dec[i] && cnt_q[i] != CNT_MAX)
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            coin_q        <= 3'b000;
            coin_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            change_done_q <= 1'b0;
            short_q       <= 1'b0;
            owed_q        <= '0;
            cnt_q[0]      <= CNT_W'(INIT_CNT_5);
            cnt_q[1]      <= CNT_W'(INIT_CNT_10);
            cnt_q[2]      <= CNT_W'(INIT_CNT_20);
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            coin_q        <= coin_d;
            coin_valid_q  <= coin_valid_d;
            busy_q        <= busy_d;
            change_done_q <= change_done_d;
            short_q       <= short_d;
            owed_q        <= owed_d;
            cnt_q         <= cnt_d;
        end
    end

    assign coin        = coin_q;
    assign coin_valid  = coin_valid_q;
    assign busy        = busy_q;
    assign change_done = change_done_q;
    assign short       = short_q;
    assign owed        = owed_q;
    assign cnt_5       = cnt_q[0];
    assign cnt_10      = cnt_q[1];
    assign cnt_20      = cnt_q[2];
endmodule
